// File: rtl/amba_axi_pkg.sv
// Shared AXI4 channel types: manager-to-subordinate and subordinate-to-manager structs,
// plus burst and response encodings.
package amba_axi_pkg;

  localparam int AXI_ADDR_W = 32;
  localparam int AXI_DATA_W = 32;
  localparam int AXI_ID_W   = 4;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef struct packed {
    logic                    awvalid;
    logic [AXI_ID_W-1:0]     awid;
    logic [AXI_ADDR_W-1:0]   awaddr;
    logic [7:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic                    wvalid;
    logic [AXI_DATA_W-1:0]   wdata;
    logic [AXI_DATA_W/8-1:0] wstrb;
    logic                    wlast;
    logic                    bready;
    logic                    arvalid;
    logic [AXI_ID_W-1:0]     arid;
    logic [AXI_ADDR_W-1:0]   araddr;
    logic [7:0]              arlen;
    logic [2:0]              arsize;
    logic [1:0]              arburst;
    logic                    rready;
  } s_axi_mosi_t;

  typedef struct packed {
    logic                  awready;
    logic                  wready;
    logic                  bvalid;
    logic [AXI_ID_W-1:0]   bid;
    logic [1:0]            bresp;
    logic                  arready;
    logic                  rvalid;
    logic [AXI_ID_W-1:0]   rid;
    logic [AXI_DATA_W-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;
  } s_axi_miso_t;

endpackage

// File: rtl/axi_mem_responder.sv
// AXI4 subordinate backed by a word-addressed register-array memory; independent write/read engines.
// Latency: W/R channel opens the cycle after AW/AR; B follows the last W by one cycle; all channels stall on the manager.
module axi_mem_responder
  import amba_axi_pkg::*;
#(
  parameter int                    MEM_WORDS = 256,
  parameter logic [AXI_ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic        clk,
  input  logic        ares,
  input  s_axi_mosi_t axi_mosi_i,
  output s_axi_miso_t axi_miso_o
);

  localparam int DATA_BYTES = AXI_DATA_W / 8;
  localparam int OFF        = $clog2(DATA_BYTES);
  localparam int WIDX       = $clog2(MEM_WORDS);
  localparam logic [AXI_ADDR_W-1:0] ONE = 1;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

  w_state_t w_state, w_nxt;
  r_state_t r_state, r_nxt;

  logic                  live;
  logic [AXI_ID_W-1:0]   w_id, r_id;
  logic [AXI_ADDR_W-1:0] w_addr, r_addr, r_addr_nxt;
  logic [7:0]            w_len, w_cnt, r_len, r_cnt;
  logic [2:0]            w_size, r_size;
  logic [1:0]            w_burst, r_burst, w_resp, r_resp, aw_dec, ar_dec;
  logic                  w_ok;
  logic [AXI_DATA_W-1:0] r_data;
  logic [AXI_DATA_W-1:0] mem [MEM_WORDS];

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs, w_last_beat, r_last_beat;

  function automatic logic [WIDX-1:0] word_idx(input logic [AXI_ADDR_W-1:0] a);
    logic [AXI_ADDR_W-1:0] off;
    off = a - BASE_ADDR;
    return WIDX'(off >> OFF);
  endfunction

  function automatic logic [AXI_ADDR_W-1:0] next_addr(input logic [AXI_ADDR_W-1:0] a,
                                                      input logic [2:0] size,
                                                      input logic [1:0] burst);
    if (burst == BURST_FIXED) return a;
    return a + (ONE << size);
  endfunction

  // Whole-burst decode: range check on first and last beat address, then protocol support.
  function automatic logic [1:0] decode(input logic [AXI_ADDR_W-1:0] addr, input logic [7:0] len,
                                        input logic [2:0] size, input logic [1:0] burst);
    logic [63:0] step, first, last, lo, hi;
    step  = 64'd1 << size;
    first = 64'(addr);
    last  = (burst == BURST_FIXED) ? first : first + 64'(len) * step;
    lo    = 64'(BASE_ADDR);
    hi    = lo + 64'(MEM_WORDS * DATA_BYTES);
    if (first < lo || first >= hi || last < lo || last >= hi) return RESP_DECERR;
    if (burst == BURST_WRAP || step > 64'(DATA_BYTES)) return RESP_SLVERR;
    return RESP_OKAY;
  endfunction

  assign aw_hs       = live && (w_state == W_IDLE) && axi_mosi_i.awvalid;
  assign w_hs        = (w_state == W_DATA) && axi_mosi_i.wvalid;
  assign b_hs        = (w_state == W_RESP) && axi_mosi_i.bready;
  assign ar_hs       = live && (r_state == R_IDLE) && axi_mosi_i.arvalid;
  assign r_hs        = (r_state == R_DATA) && axi_mosi_i.rready;
  assign w_last_beat = (w_cnt == w_len);
  assign r_last_beat = (r_cnt == r_len);
  assign aw_dec      = decode(axi_mosi_i.awaddr, axi_mosi_i.awlen, axi_mosi_i.awsize, axi_mosi_i.awburst);
  assign ar_dec      = decode(axi_mosi_i.araddr, axi_mosi_i.arlen, axi_mosi_i.arsize, axi_mosi_i.arburst);
  assign r_addr_nxt  = next_addr(r_addr, r_size, r_burst);

  // Holds readys low until the first edge after reset release.
  always_ff @(posedge clk or posedge ares) begin
    if (ares) begin
      live    <= 1'b0;
      w_state <= W_IDLE;
      r_state <= R_IDLE;
    end else begin
      live    <= 1'b1;
      w_state <= w_nxt;
      r_state <= r_nxt;
    end
  end

  always_comb begin
    w_nxt      = w_state;
    r_nxt      = r_state;
    axi_miso_o = '0;
    unique case (w_state)
      W_IDLE:  if (aw_hs) w_nxt = W_DATA;
      W_DATA:  if (w_hs && w_last_beat) w_nxt = W_RESP;
      W_RESP:  if (b_hs) w_nxt = W_IDLE;
      default: w_nxt = W_IDLE;
    endcase
    unique case (r_state)
      R_IDLE:  if (ar_hs) r_nxt = R_DATA;
      R_DATA:  if (r_hs && r_last_beat) r_nxt = R_IDLE;
      default: r_nxt = R_IDLE;
    endcase
    axi_miso_o.awready = live && (w_state == W_IDLE);
    axi_miso_o.wready  = (w_state == W_DATA);
    axi_miso_o.bvalid  = (w_state == W_RESP);
    axi_miso_o.bid     = w_id;
    axi_miso_o.bresp   = w_resp;
    axi_miso_o.arready = live && (r_state == R_IDLE);
    axi_miso_o.rvalid  = (r_state == R_DATA);
    axi_miso_o.rid     = r_id;
    axi_miso_o.rdata   = r_data;
    axi_miso_o.rresp   = r_resp;
    axi_miso_o.rlast   = (r_state == R_DATA) && r_last_beat;
  end

  always_ff @(posedge clk or posedge ares) begin
    if (ares) begin
      w_id <= '0; w_addr <= '0; w_len <= '0; w_cnt <= '0;
      w_size <= '0; w_burst <= '0; w_resp <= '0; w_ok <= 1'b0;
    end else if (aw_hs) begin
      w_id    <= axi_mosi_i.awid;
      w_addr  <= axi_mosi_i.awaddr;
      w_len   <= axi_mosi_i.awlen;
      w_cnt   <= '0;
      w_size  <= axi_mosi_i.awsize;
      w_burst <= axi_mosi_i.awburst;
      w_resp  <= aw_dec;
      w_ok    <= (aw_dec == RESP_OKAY);
    end else if (w_hs) begin
      w_addr <= next_addr(w_addr, w_size, w_burst);
      w_cnt  <= w_cnt + 8'd1;
      // A misplaced wlast downgrades the response but the beat count still ends the burst.
      if ((axi_mosi_i.wlast != w_last_beat) && (w_resp == RESP_OKAY)) w_resp <= RESP_SLVERR;
    end
  end

  always_ff @(posedge clk) begin
    if (w_hs && w_ok) begin
      for (int b = 0; b < DATA_BYTES; b++) begin
        if (axi_mosi_i.wstrb[b]) mem[word_idx(w_addr)][8*b +: 8] <= axi_mosi_i.wdata[8*b +: 8];
      end
    end
  end

  // Read data is registered one beat ahead so it stays frozen under backpressure.
  always_ff @(posedge clk or posedge ares) begin
    if (ares) begin
      r_id <= '0; r_addr <= '0; r_len <= '0; r_cnt <= '0;
      r_size <= '0; r_burst <= '0; r_resp <= '0; r_data <= '0;
    end else if (ar_hs) begin
      r_id    <= axi_mosi_i.arid;
      r_addr  <= axi_mosi_i.araddr;
      r_len   <= axi_mosi_i.arlen;
      r_cnt   <= '0;
      r_size  <= axi_mosi_i.arsize;
      r_burst <= axi_mosi_i.arburst;
      r_resp  <= ar_dec;
      r_data  <= (ar_dec == RESP_OKAY) ? mem[word_idx(axi_mosi_i.araddr)] : '0;
    end else if (r_hs && !r_last_beat) begin
      r_addr <= r_addr_nxt;
      r_cnt  <= r_cnt + 8'd1;
      r_data <= (r_resp == RESP_OKAY) ? mem[word_idx(r_addr_nxt)] : '0;
    end
  end

endmodule

// File: tb/tb_axi_mem_responder.sv
// Directed bench for axi_mem_responder: single-beat vector table plus burst, strobe, error,
// concurrency and mid-burst reset sequences.
module tb_axi_mem_responder;
  import amba_axi_pkg::*;

  logic        clk = 1'b0;
  logic        ares;
  s_axi_mosi_t mosi;
  s_axi_miso_t miso;
  int          ncmp = 0;
  int          nerr = 0;

  always #5 clk = ~clk;

  axi_mem_responder #(.MEM_WORDS(16), .BASE_ADDR(32'h0000_1000)) dut (
    .clk        (clk),
    .ares       (ares),
    .axi_mosi_i (mosi),
    .axi_miso_o (miso)
  );

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [3:0]  id;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [1:0]  resp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic expire(input string name);
    ncmp++;
    nerr++;
    $display("FAIL %s: timed out waiting for handshake", name);
  endtask

  task automatic aw_req(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                        input logic [2:0] size, input logic [1:0] burst);
    bit ok = 0;
    mosi.awaddr = addr; mosi.awid = id; mosi.awlen = len;
    mosi.awsize = size; mosi.awburst = burst; mosi.awvalid = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin @(negedge clk); ok = miso.awready; end
    if (!ok) expire("aw");
    else begin @(posedge clk); #1; check("wready_after_aw", 32'(miso.wready), 32'd1); end
    mosi.awvalid = 1'b0;
  endtask

  task automatic ar_req(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                        input logic [2:0] size, input logic [1:0] burst);
    bit ok = 0;
    mosi.araddr = addr; mosi.arid = id; mosi.arlen = len;
    mosi.arsize = size; mosi.arburst = burst; mosi.arvalid = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin @(negedge clk); ok = miso.arready; end
    if (!ok) expire("ar");
    else begin @(posedge clk); #1; check("rvalid_after_ar", 32'(miso.rvalid), 32'd1); end
    mosi.arvalid = 1'b0;
  endtask

  task automatic w_beat(input logic [31:0] data, input logic [3:0] strb, input logic last);
    bit ok = 0;
    mosi.wdata = data; mosi.wstrb = strb; mosi.wlast = last; mosi.wvalid = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin @(negedge clk); ok = miso.wready; end
    if (!ok) expire("w");
    else begin @(posedge clk); #1; end
    mosi.wvalid = 1'b0;
  endtask

  task automatic b_get(input logic [3:0] exp_id, input logic [1:0] exp_resp);
    bit ok = 0;
    mosi.bready = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin @(negedge clk); ok = miso.bvalid; end
    if (!ok) expire("b");
    else begin
      check("bid", 32'(miso.bid), 32'(exp_id));
      check("bresp", 32'(miso.bresp), 32'(exp_resp));
      @(posedge clk); #1;
      mosi.bready = 1'b0;
      check("awready_after_b", 32'(miso.awready), 32'd1);
    end
    mosi.bready = 1'b0;
  endtask

  task automatic r_get(output logic [31:0] data, output logic [1:0] resp,
                       output logic last, output logic [3:0] id);
    bit ok = 0;
    data = '0; resp = '0; last = 1'b0; id = '0;
    mosi.rready = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin @(negedge clk); ok = miso.rvalid; end
    if (!ok) expire("r");
    else begin
      data = miso.rdata; resp = miso.rresp; last = miso.rlast; id = miso.rid;
      @(posedge clk); #1;
    end
    mosi.rready = 1'b0;
  endtask

  task automatic wr1(input logic [31:0] addr, input logic [31:0] data);
    aw_req(addr, 4'd0, 8'd0, 3'd2, BURST_INCR);
    w_beat(data, 4'hF, 1'b1);
    b_get(4'd0, RESP_OKAY);
  endtask

  task automatic rd1_check(input string name, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] d; logic [1:0] rs; logic l; logic [3:0] id;
    ar_req(addr, 4'd0, 8'd0, 3'd2, BURST_INCR);
    r_get(d, rs, l, id);
    check(name, d, exp);
    check({name, "_resp"}, 32'(rs), 32'(RESP_OKAY));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running, want done");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vt [14];
    logic [31:0] d, d0;
    logic [1:0]  rs;
    logic        l;
    logic [3:0]  id;

    vt[0]  = '{1'b1, 32'h1010, 4'd5,  32'hDEADBEEF, 4'hF, 3'd2, BURST_INCR, RESP_OKAY};
    vt[1]  = '{1'b0, 32'h1010, 4'd7,  32'hDEADBEEF, 4'h0, 3'd2, BURST_INCR, RESP_OKAY};
    vt[2]  = '{1'b1, 32'h1004, 4'd1,  32'hAAAAAAAA, 4'hF, 3'd2, BURST_INCR, RESP_OKAY};
    vt[3]  = '{1'b1, 32'h1004, 4'd2,  32'h12345678, 4'h5, 3'd2, BURST_INCR, RESP_OKAY};
    vt[4]  = '{1'b0, 32'h1004, 4'd3,  32'hAA34AA78, 4'h0, 3'd2, BURST_INCR, RESP_OKAY};
    vt[5]  = '{1'b1, 32'h1008, 4'd4,  32'h01020304, 4'hF, 3'd2, BURST_INCR, RESP_OKAY};
    vt[6]  = '{1'b1, 32'h1008, 4'd6,  32'hFFFFFFFF, 4'hF, 3'd3, BURST_INCR, RESP_SLVERR};
    vt[7]  = '{1'b0, 32'h1008, 4'd8,  32'h01020304, 4'h0, 3'd2, BURST_INCR, RESP_OKAY};
    vt[8]  = '{1'b1, 32'h1040, 4'd9,  32'h77777777, 4'hF, 3'd2, BURST_INCR, RESP_DECERR};
    vt[9]  = '{1'b0, 32'h0FFC, 4'd10, 32'h00000000, 4'h0, 3'd2, BURST_INCR, RESP_DECERR};
    vt[10] = '{1'b1, 32'h103C, 4'd11, 32'hCAFEF00D, 4'hF, 3'd2, BURST_INCR, RESP_OKAY};
    vt[11] = '{1'b0, 32'h103C, 4'd12, 32'hCAFEF00D, 4'h0, 3'd2, BURST_INCR, RESP_OKAY};
    vt[12] = '{1'b0, 32'h1013, 4'd13, 32'hDEADBEEF, 4'h0, 3'd2, BURST_INCR, RESP_OKAY};
    vt[13] = '{1'b0, 32'h1010, 4'd14, 32'h00000000, 4'h0, 3'd2, BURST_WRAP, RESP_SLVERR};

    mosi = '0;
    ares = 1'b1;
    #12;
    check("rst_awready", 32'(miso.awready), 32'd0);
    check("rst_arready", 32'(miso.arready), 32'd0);
    check("rst_valids", 32'({miso.wready, miso.bvalid, miso.rvalid}), 32'd0);
    check("rst_payload", miso.rdata | 32'(miso.bid) | 32'(miso.rresp), 32'd0);
    @(negedge clk); ares = 1'b0; #1;
    check("awready_before_edge", 32'(miso.awready), 32'd0);
    @(posedge clk); #1;
    check("awready_after_rel", 32'(miso.awready), 32'd1);
    check("arready_after_rel", 32'(miso.arready), 32'd1);

    for (int k = 0; k < 14; k++) begin
      if (vt[k].wr) begin
        aw_req(vt[k].addr, vt[k].id, 8'd0, vt[k].size, vt[k].burst);
        w_beat(vt[k].data, vt[k].strb, 1'b1);
        check($sformatf("v%0d_bvalid_lat", k), 32'(miso.bvalid), 32'd1);
        b_get(vt[k].id, vt[k].resp);
      end else begin
        ar_req(vt[k].addr, vt[k].id, 8'd0, vt[k].size, vt[k].burst);
        r_get(d, rs, l, id);
        check($sformatf("v%0d_rid", k), 32'(id), 32'(vt[k].id));
        check($sformatf("v%0d_rresp", k), 32'(rs), 32'(vt[k].resp));
        check($sformatf("v%0d_rdata", k), d, vt[k].data);
        check($sformatf("v%0d_rlast", k), 32'(l), 32'd1);
      end
    end

    // INCR burst write then read with rready toggling.
    aw_req(32'h1000, 4'd3, 8'd3, 3'd2, BURST_INCR);
    for (int k = 0; k < 4; k++) w_beat(32'h11 * (k + 1), 4'hF, 1'(k == 3));
    check("burst_bvalid_lat", 32'(miso.bvalid), 32'd1);
    b_get(4'd3, RESP_OKAY);
    ar_req(32'h1000, 4'd4, 8'd3, 3'd2, BURST_INCR);
    for (int k = 0; k < 4; k++) begin
      mosi.rready = 1'b0;
      @(negedge clk);
      d0 = miso.rdata;
      check($sformatf("burst_rvalid%0d", k), 32'(miso.rvalid), 32'd1);
      @(negedge clk);
      check($sformatf("burst_stall%0d", k), miso.rdata, d0);
      check($sformatf("burst_rdata%0d", k), miso.rdata, 32'h11 * (k + 1));
      check($sformatf("burst_rlast%0d", k), 32'(miso.rlast), 32'(k == 3));
      mosi.rready = 1'b1;
      @(posedge clk); #1;
      mosi.rready = 1'b0;
    end
    check("burst_arready_after", 32'(miso.arready), 32'd1);
    check("burst_rvalid_after", 32'(miso.rvalid), 32'd0);

    // FIXED burst with byte strobes.
    wr1(32'h1020, 32'hAABBCCDD);
    aw_req(32'h1020, 4'd2, 8'd1, 3'd2, BURST_FIXED);
    w_beat(32'h000000EE, 4'h1, 1'b0);
    w_beat(32'h0000FF00, 4'h2, 1'b1);
    b_get(4'd2, RESP_OKAY);
    rd1_check("fixed_strb", 32'h1020, 32'hAABBFFEE);

    // DECERR read just past the end.
    ar_req(32'h1040, 4'd6, 8'd1, 3'd2, BURST_INCR);
    for (int k = 0; k < 2; k++) begin
      r_get(d, rs, l, id);
      check($sformatf("dec_rdata%0d", k), d, 32'd0);
      check($sformatf("dec_rresp%0d", k), 32'(rs), 32'(RESP_DECERR));
      check($sformatf("dec_rlast%0d", k), 32'(l), 32'(k == 1));
    end

    // WRAP write is rejected and leaves memory alone.
    aw_req(32'h1010, 4'd9, 8'd1, 3'd2, BURST_WRAP);
    w_beat(32'h55555555, 4'hF, 1'b0);
    w_beat(32'h55555555, 4'hF, 1'b1);
    b_get(4'd9, RESP_SLVERR);
    rd1_check("wrap_unchanged", 32'h1010, 32'hDEADBEEF);

    // Early wlast on a two-beat burst.
    aw_req(32'h1030, 4'd8, 8'd1, 3'd2, BURST_INCR);
    w_beat(32'h1, 4'hF, 1'b1);
    w_beat(32'h2, 4'hF, 1'b1);
    b_get(4'd8, RESP_SLVERR);

    // Read and write to the same word in the same cycles.
    mosi.awaddr = 32'h1010; mosi.awid = 4'd1; mosi.awlen = 8'd0; mosi.awsize = 3'd2;
    mosi.awburst = BURST_INCR; mosi.awvalid = 1'b1;
    mosi.araddr = 32'h1010; mosi.arid = 4'd2; mosi.arlen = 8'd0; mosi.arsize = 3'd2;
    mosi.arburst = BURST_INCR; mosi.arvalid = 1'b1;
    @(negedge clk);
    check("conc_readys", 32'({miso.awready, miso.arready}), 32'd3);
    @(posedge clk); #1;
    mosi.awvalid = 1'b0; mosi.arvalid = 1'b0;
    mosi.wdata = 32'h0BADF00D; mosi.wstrb = 4'hF; mosi.wlast = 1'b1; mosi.wvalid = 1'b1;
    mosi.rready = 1'b1;
    @(negedge clk);
    check("conc_w_r_open", 32'({miso.wready, miso.rvalid}), 32'd3);
    check("conc_old_value", miso.rdata, 32'hDEADBEEF);
    @(posedge clk); #1;
    mosi.wvalid = 1'b0; mosi.rready = 1'b0;
    b_get(4'd1, RESP_OKAY);
    rd1_check("conc_new_value", 32'h1010, 32'h0BADF00D);

    // Reset during beat 2 of an eight-beat read.
    ar_req(32'h1000, 4'd5, 8'd7, 3'd2, BURST_INCR);
    mosi.rready = 1'b1;
    for (int k = 0; k < 2; k++) @(posedge clk);
    @(negedge clk);
    check("rst_mid_rdata_b2", miso.rdata, 32'h33);
    ares = 1'b1; #1;
    check("rst_mid_rvalid", 32'(miso.rvalid), 32'd0);
    check("rst_mid_arready", 32'(miso.arready), 32'd0);
    mosi.rready = 1'b0;
    @(posedge clk); @(negedge clk);
    ares = 1'b0; #1;
    check("rst_mid_arready_rel", 32'(miso.arready), 32'd0);
    @(posedge clk); #1;
    check("rst_mid_arready_edge", 32'(miso.arready), 32'd1);
    check("rst_mid_rvalid_edge", 32'(miso.rvalid), 32'd0);
    rd1_check("post_rst_read", 32'h1000, 32'h11);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
